tff_counter_n: RTL and testbench

- Parametrised N-bit synchronous counter built from per-bit toggle (T) flip-flop cells. Each cell has complementary outputs.
- Generalises the single-bit T flip-flop with preset/clear into a modulo-M up/down counter with parallel load, terminal-count flag and wrap pulse.
- Used as the counting primitive for dividers and sequencers in the computer-architecture lab designs.

---
 rtl/tff_counter_n.sv | 83 ++++++++
 tb/tb_tff_counter_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tff_counter_n.sv
// Modulo-MODULUS up/down counter built from per-bit toggle cells with complementary
// outputs, preset, saturating parallel load, terminal-count flag and wrap pulse.
module tff_counter_n #(
   parameter int     WIDTH      = 4,
   parameter longint MODULUS    = 16,
   parameter longint PRESET_VAL = MODULUS - 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             pre,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] PREV = WIDTH'(PRESET_VAL);
   localparam bit               FULL = (MODULUS == (longint'(1) << WIDTH));

   if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (longint'(1) << WIDTH) ||
       PRESET_VAL < 0 || PRESET_VAL >= MODULUS) begin : g_param_check
      $error("tff_counter_n: illegal WIDTH/MODULUS/PRESET_VAL combination");
   end

   logic [WIDTH-1:0] t_cnt;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] ld_val;

   if (FULL) begin : g_bin
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i == 0) begin : g_lsb
            assign t_cnt[i] = 1'b1;
         end else begin : g_upper
            assign t_cnt[i] = up_dn ? (&q[i-1:0]) : ~(|q[i-1:0]);
         end
      end
   end else begin : g_mod
      logic [WIDTH-1:0] nxt;
      always_comb begin
         nxt = q;
         if (up_dn) nxt = (q == MAXV) ? '0 : q + 1'b1;
         else       nxt = (q == '0) ? MAXV : q - 1'b1;
      end
      assign t_cnt = q ^ nxt;
   end

   always_comb begin
      ld_val = din;
      if (pre)                    ld_val = PREV;
      else if ({1'b0, din} >= MODW) ld_val = MAXV;
   end

   // Loads are also expressed as toggles (q ^ target) so every cell stays a pure T-FF.
   always_comb begin
      t = '0;
      if (pre || load) t = q ^ ld_val;
      else if (en)     t = t_cnt;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic qb;
      always_ff @(posedge clk or posedge clr) begin
         if (clr)       qb <= 1'b0;
         else if (t[i]) qb <= ~qb;
      end
      assign q[i] = qb;
   end

   assign qn = ~q;
   assign tc = up_dn ? (q == MAXV) : (q == '0);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) wrap <= 1'b0;
      else     wrap <= en & tc & ~pre & ~load;
   end

endmodule

// File: tb/tb_tff_counter_n.sv
// Bench for tff_counter_n: a MODULUS=10 and a full-binary MODULUS=8 instance checked
// every cycle against an arithmetic model, plus hand-computed directed expectations.
module tb_tff_counter_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr_a = 1'b0, pre_a = 1'b0, load_a = 1'b0, en_a = 1'b0, ud_a = 1'b1;
   logic [3:0] din_a = '0;
   logic [3:0] q_a, qn_a;
   logic       tc_a, wrap_a;

   logic       clr_b = 1'b0, pre_b = 1'b0, load_b = 1'b0, en_b = 1'b0, ud_b = 1'b1;
   logic [2:0] din_b = '0;
   logic [2:0] q_b, qn_b;
   logic       tc_b, wrap_b;

   tff_counter_n #(.WIDTH(4), .MODULUS(10)) dut_a (
      .clk(clk), .clr(clr_a), .pre(pre_a), .load(load_a), .din(din_a), .en(en_a),
      .up_dn(ud_a), .q(q_a), .qn(qn_a), .tc(tc_a), .wrap(wrap_a));

   tff_counter_n #(.WIDTH(3), .MODULUS(8)) dut_b (
      .clk(clk), .clr(clr_b), .pre(pre_b), .load(load_b), .din(din_b), .en(en_b),
      .up_dn(ud_b), .q(q_b), .qn(qn_b), .tc(tc_b), .wrap(wrap_b));

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic int tcm(input int m, input logic ud, input int md);
      return ud ? int'(m == md - 1) : int'(m == 0);
   endfunction

   // Arithmetic reference model: integer count modulo M, wrap flag from the previous edge.
   int ma = 0, wa = 0, mb = 0, wb = 0;

   always @(posedge clk or posedge clr_a) begin
      if (clr_a) begin
         ma = 0; wa = 0;
      end else begin
         wa = (!pre_a && !load_a && en_a) ? tcm(ma, ud_a, 10) : 0;
         if (pre_a)       ma = 9;
         else if (load_a) ma = (int'(din_a) < 10) ? int'(din_a) : 9;
         else if (en_a)   ma = ud_a ? (ma + 1) % 10 : (ma + 9) % 10;
      end
   end

   always @(posedge clk or posedge clr_b) begin
      if (clr_b) begin
         mb = 0; wb = 0;
      end else begin
         wb = (!pre_b && !load_b && en_b) ? tcm(mb, ud_b, 8) : 0;
         if (pre_b)       mb = 7;
         else if (load_b) mb = int'(din_b);
         else if (en_b)   mb = ud_b ? (mb + 1) % 8 : (mb + 7) % 8;
      end
   end

   always @(negedge clk) begin
      chk("model_q_a", int'(q_a), ma);
      chk("model_qn_a", int'(qn_a), (~ma) & 15);
      chk("model_tc_a", int'(tc_a), tcm(ma, ud_a, 10));
      chk("model_wrap_a", int'(wrap_a), wa);
      chk("model_q_b", int'(q_b), mb);
      chk("model_qn_b", int'(qn_b), (~mb) & 7);
      chk("model_tc_b", int'(tc_b), tcm(mb, ud_b, 8));
      chk("model_wrap_b", int'(wrap_b), wb);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int up_exp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int dn_exp[3]  = '{0, 9, 8};

   initial begin
      #1;
      clr_a = 1'b1; clr_b = 1'b1;
      #1;
      chk("rst_q_a", int'(q_a), 0);
      chk("rst_qn_a", int'(qn_a), 15);
      chk("rst_wrap_a", int'(wrap_a), 0);
      chk("rst_q_b", int'(q_b), 0);
      chk("rst_qn_b", int'(qn_b), 7);
      tick();
      clr_a = 1'b0; clr_b = 1'b0;

      // Async clear while counting at 7
      en_a = 1'b1; ud_a = 1'b1;
      repeat (7) tick();
      chk("cnt_to_7", int'(q_a), 7);
      clr_a = 1'b1;
      #1;
      chk("clr_q_now", int'(q_a), 0);
      chk("clr_qn_now", int'(qn_a), 15);
      chk("clr_wrap_now", int'(wrap_a), 0);
      tick();
      chk("clr_hold_q", int'(q_a), 0);
      clr_a = 1'b0; en_a = 1'b0;
      tick();

      // Up wrap through 9 -> 0
      en_a = 1'b1; ud_a = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("up_q", int'(q_a), up_exp[k]);
         chk("up_wrap", int'(wrap_a), int'(k == 9));
         chk("up_tc", int'(tc_a), int'(up_exp[k] == 9));
      end

      // Down wrap from 1
      ud_a = 1'b0;
      tick();
      chk("dn_start", int'(q_a), 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("dn_q", int'(q_a), dn_exp[k]);
         chk("dn_wrap", int'(wrap_a), int'(k == 1));
         chk("dn_tc", int'(tc_a), int'(k == 0));
      end

      // Priority and saturating load
      en_a = 1'b0; pre_a = 1'b1; load_a = 1'b1; din_a = 4'd3;
      tick();
      chk("pre_over_load", int'(q_a), 9);
      chk("pre_wrap", int'(wrap_a), 0);
      pre_a = 1'b0; din_a = 4'd14;
      tick();
      chk("sat_load", int'(q_a), 9);
      din_a = 4'd5; en_a = 1'b1;
      tick();
      chk("load_over_cnt", int'(q_a), 5);
      chk("load_wrap", int'(wrap_a), 0);

      // Pending load does not survive a clear
      en_a = 1'b0; din_a = 4'd3;
      clr_a = 1'b1;
      #1;
      chk("clr_vs_load", int'(q_a), 0);
      tick();
      clr_a = 1'b0; load_a = 1'b0;
      tick();
      chk("after_clr", int'(q_a), 0);

      // Full binary: hold at 6, then count through 7 -> 0
      load_b = 1'b1; din_b = 3'd6;
      tick();
      chk("b_load6", int'(q_b), 6);
      load_b = 1'b0; en_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("b_hold", int'(q_b), 6);
      end
      en_b = 1'b1; ud_b = 1'b1;
      tick();
      chk("b_q7", int'(q_b), 7);
      chk("b_w7", int'(wrap_b), 0);
      tick();
      chk("b_q0", int'(q_b), 0);
      chk("b_w0", int'(wrap_b), 1);
      tick();
      chk("b_q1", int'(q_b), 1);
      chk("b_w1", int'(wrap_b), 0);

      // Alternate direction every edge from 0
      en_b = 1'b0; load_b = 1'b1; din_b = 3'd0;
      tick();
      load_b = 1'b0; en_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ud_b = (k % 2 == 0);
         tick();
         chk("mix_q", int'(q_b), (k % 2 == 0) ? 1 : 0);
         chk("mix_wrap", int'(wrap_b), 0);
      end
      en_b = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
